rf_wport_arbiter: RTL
=====================

RF_WPORT_ARBITER -- requirements
Module: rf_wport_arbiter

Interface
REQ-001 Parameter: LQ_DEPTH, default 2, late-result queue entries.
REQ-002 Parameter: STARVE_MAX, default 7, consecutive lost-grant cycles before the WB stage is held.
REQ-003 Port: clk  in  1  single clock, all state on rising edge.
REQ-004 Port: rst_n  in  1  reset, asynchronous, active-low.
REQ-005 Port: wb_we  in  4  pipeline WB byte-write enables; any bit set means a WB request.
REQ-006 Port: wb_waddr  in  5  WB destination register.
REQ-007 Port: wb_wdata  in  32  WB data.
REQ-008 Port: lu_valid  in  1  late unit (mul/div) result valid.
REQ-009 Port: lu_ready  out  1  queue can accept a late result.
REQ-010 Port: lu_we  in  4  late result byte enables.
REQ-011 Port: lu_waddr  in  5  late result register.
REQ-012 Port: lu_wdata  in  32  late result data.
REQ-013 Port: lu_issue  in  1  long op issued this cycle; mark destination pending.
REQ-014 Port: lu_issue_addr  in  5  destination of issued long op.
REQ-015 Port: ren1, ren2  in  1 each  ID read-port enables.
REQ-016 Port: raddr1, raddr2  in  5 each  ID read addresses.
REQ-017 Port: stallreq  out  1  ID reads a pending register.
REQ-018 Port: wb_hold  out  1  WB stage must freeze this cycle.
REQ-019 Port: rf_we  out  4  regfile write enables.
REQ-020 Port: rf_waddr  out  5  regfile write address.
REQ-021 Port: rf_wdata  out  32  regfile write data.

Function
REQ-022 Grant priority per cycle: wb_hold high -> queue head; else WB request -> WB; else queue non-empty -> head; else lu_valid -> direct late write; else rf_we = 0.
REQ-023 rf_* outputs are combinational from the granted source, zero added latency.
REQ-024 Direct late write (queue empty, no WB request, no hold) does not occupy a queue entry.
REQ-025 lu_ready = queue not full; a push occurs on lu_valid && lu_ready when the late result is not written directly.
REQ-026 Queue is FIFO, circular pointers wrap modulo LQ_DEPTH; simultaneous push and pop when full is not possible (lu_ready low); push and pop in one cycle when partially full keeps occupancy unchanged.
REQ-027 Starve counter: increments each cycle the queue is non-empty and not granted, clears on any queue grant or empty queue, saturates at STARVE_MAX.
REQ-028 wb_hold = (counter == STARVE_MAX) && queue non-empty; WB request is ignored that cycle; pipeline re-presents it.
REQ-029 Pending vector, 32 bits: set bit lu_issue_addr on lu_issue; clear bit rf_waddr when a late result (queued or direct) is written; set wins over clear for the same register in the same cycle.
REQ-030 Register 0 is never pending; lu_issue to 0 and late writes to 0 are ignored for pending.
REQ-031 WB writes never clear pending bits.
REQ-032 stallreq = (ren1 && pending[raddr1]) || (ren2 && pending[raddr2]), combinational.

Reset
REQ-033 While rst_n low: queue empty, pointers 0, counter 0, pending all 0, rf_we = 0, wb_hold = 0, stallreq = 0, lu_ready = 1.
REQ-034 Reset mid-operation discards queued results and pending marks with no regfile write.

Structure
REQ-035 Shared package holds LQ_DEPTH, STARVE_MAX, register-address width 5, data width 32, byte-enable width 4, and the queue-entry typedef {we, waddr, wdata}.
REQ-036 Queue is one sub-module, lq_fifo, with push/pop/full/empty and a head-entry output.

Verification
REQ-037 lu_issue to r5, then lu_valid r5=0x12345678 with no WB -> rf_we=4'hF, rf_waddr=5, same cycle; pending[5] clears next cycle; ren1/raddr1=5 stalls until then.
REQ-038 WB every cycle, two late results -> both queued, lu_ready falls at 2 entries, third result held.
REQ-039 WB every cycle with queue non-empty -> wb_hold high on the 8th lost cycle, head written, counter cleared.
REQ-040 lu_issue r7 and a late write to r7 in the same cycle -> pending[7] remains 1.
REQ-041 lu_issue to r0 with ren1/raddr1=0 -> stallreq stays 0.
REQ-042 Assert rst_n low with 2 queued entries -> rf_we 0 immediately, lu_ready 1, pending 0, no stale write after release.

Source files
------------

// File: rtl/rf_wport_arbiter_pkg.sv
// Shared constants and types for the register-file write-port arbiter.
// Holds default queue depth, starvation limit, datapath widths and the
// late-result queue entry layout used by the arbiter and its queue.
package rf_wport_arbiter_pkg;

  localparam int LQ_DEPTH   = 2;   // late-result queue entries
  localparam int STARVE_MAX = 7;   // lost-grant cycles before WB is held
  localparam int AW         = 5;   // register address width
  localparam int DW         = 32;  // register data width
  localparam int BW         = 4;   // byte-enable width

  typedef struct packed {
    logic [BW-1:0] we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
  } lq_entry_t;

endpackage

// File: rtl/rf_wport_arbiter_lq_fifo.sv
// Purpose: circular FIFO holding late (mul/div) results awaiting the write port.
// Latency: push visible at head the cycle after; pop is combinational on head.
// Backpressure: full blocks the producer; push and pop on full never coincide.
// Ports: clk, rst_n (async active-low), push/din, pop, head, full, empty.
module lq_fifo
  import rf_wport_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  lq_entry_t din,
  input  logic      pop,
  output lq_entry_t head,
  output logic      full,
  output logic      empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  lq_entry_t       mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // Storage needs no reset: the occupancy count alone defines validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap modulo DEPTH so non-power-of-two depths work too.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/rf_wport_arbiter.sv
// Purpose: arbitrates the single regfile write port between WB and late results.
// Latency: rf_* are combinational from the granted source (zero cycles).
// Backpressure: lu_ready drops when the late queue is full; wb_hold freezes WB
//   after STARVE_MAX lost cycles so a queued late result can drain.
// Ports: WB write (wb_we/waddr/wdata), late result (lu_valid/ready/we/waddr/
//   wdata), long-op issue (lu_issue/_addr), ID reads (ren*/raddr*) -> stallreq,
//   wb_hold, and the regfile write (rf_we/waddr/wdata).
module rf_wport_arbiter
  import rf_wport_arbiter_pkg::*;
#(
  parameter int LQ_DEPTH   = rf_wport_arbiter_pkg::LQ_DEPTH,
  parameter int STARVE_MAX = rf_wport_arbiter_pkg::STARVE_MAX
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [BW-1:0] wb_we,
  input  logic [AW-1:0] wb_waddr,
  input  logic [DW-1:0] wb_wdata,
  input  logic          lu_valid,
  output logic          lu_ready,
  input  logic [BW-1:0] lu_we,
  input  logic [AW-1:0] lu_waddr,
  input  logic [DW-1:0] lu_wdata,
  input  logic          lu_issue,
  input  logic [AW-1:0] lu_issue_addr,
  input  logic          ren1,
  input  logic [AW-1:0] raddr1,
  input  logic          ren2,
  input  logic [AW-1:0] raddr2,
  output logic          stallreq,
  output logic          wb_hold,
  output logic [BW-1:0] rf_we,
  output logic [AW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata
);

  localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  lq_entry_t      q_head;
  lq_entry_t      q_din;
  logic           q_full;
  logic           q_empty;
  logic           q_push;
  logic           wb_req;
  logic           grant_q;
  logic           grant_wb;
  logic           grant_direct;
  logic           late_wr;
  logic [SW-1:0]  starve_cnt;
  logic [31:0]    pending;
  logic [31:0]    pending_nxt;

  assign wb_req  = |wb_we;
  assign wb_hold = (starve_cnt == SW'(STARVE_MAX)) && !q_empty;

  // Grants are qualified by rst_n so no write leaks out while reset is held.
  assign grant_q      = rst_n && !q_empty && (wb_hold || !wb_req);
  assign grant_wb     = rst_n && wb_req && !wb_hold;
  assign grant_direct = rst_n && q_empty && !wb_req && lu_valid;
  assign late_wr      = grant_q || grant_direct;

  // A late result written straight through never occupies a queue slot.
  assign lu_ready = !q_full;
  assign q_push   = lu_valid && !q_full && !grant_direct;
  assign q_din    = '{we: lu_we, waddr: lu_waddr, wdata: lu_wdata};

  lq_fifo #(
    .DEPTH (LQ_DEPTH)
  ) u_lq_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (q_push),
    .din   (q_din),
    .pop   (grant_q),
    .head  (q_head),
    .full  (q_full),
    .empty (q_empty)
  );

  always_comb begin
    rf_we    = '0;
    rf_waddr = '0;
    rf_wdata = '0;
    if (grant_q) begin
      rf_we    = q_head.we;
      rf_waddr = q_head.waddr;
      rf_wdata = q_head.wdata;
    end else if (grant_wb) begin
      rf_we    = wb_we;
      rf_waddr = wb_waddr;
      rf_wdata = wb_wdata;
    end else if (grant_direct) begin
      rf_we    = lu_we;
      rf_waddr = lu_waddr;
      rf_wdata = lu_wdata;
    end
  end

  // Counts cycles the queue head waited while WB took the port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (q_empty || grant_q) begin
      starve_cnt <= '0;
    end else if (starve_cnt != SW'(STARVE_MAX)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Only late writes retire pending marks; a new issue to the same register
  // in the same cycle must stay pending, so the set is applied last.
  always_comb begin
    pending_nxt = pending;
    if (late_wr) begin
      pending_nxt[rf_waddr] = 1'b0;
    end
    if (lu_issue) begin
      pending_nxt[lu_issue_addr] = 1'b1;
    end
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      pending <= pending_nxt;
    end
  end

  assign stallreq = (ren1 && pending[raddr1]) || (ren2 && pending[raddr2]);

endmodule
